link_sync_ctrl: RTL and testbench
=================================

Name: link_sync_ctrl

Overview:
- Link bring-up and word-alignment controller for the 8b/10b SerDes path.
- Sits on the 8-bit side, between user logic and the encoder/decoder.
- Sends K28.5 commas during training, finds RX word alignment by pulsing a bitslip request to the SIPO, declares link up after consecutive clean commas, then passes user data.
- Drops back to training when the decoded error rate crosses a threshold.

Parameters:
- SLIP_WAIT, 16: cycles in HUNT without a clean comma before one Bitslip pulse is issued.
- SYNC_COMMAS, 4: consecutive clean commas needed to declare link up.
- ERR_THRESH, 4: leaky error-counter level that forces link down.
- GOOD_WINDOW, 8: consecutive clean words that decrement the leaky error counter by 1.
- ERR_CNT_W, 16: width of the saturating Error_Count output.

Ports:
- BitCLK_10  in  1  word clock, one cycle per 10-bit symbol.
- Reset  in  1  synchronous, active-high.
- Tx_Valid  in  1  user has a word to send.
- Tx_Data_User  in  8  user data byte.
- Tx_K_User  in  1  user byte is a control character.
- RxParallel_8  in  8  decoded byte from the decoder.
- RxDataK  in  1  decoded byte is a K character.
- Decode_Error  in  1  invalid code group this word.
- Disparity_Error  in  1  running-disparity violation this word.
- TxParallel_8  out  8  byte to the encoder.
- TxDataK  out  1  K flag to the encoder.
- Tx_Ready  out  1  user word accepted this cycle when Tx_Valid=1.
- Bitslip  out  1  one-cycle request to the SIPO to shift alignment by one bit.
- Link_Up  out  1  link trained.
- Rx_Valid  out  1  Rx_Data/Rx_K carry a user word.
- Rx_Data  out  8  received user byte.
- Rx_K  out  1  received user byte is K.
- Error_Count  out  ERR_CNT_W  saturating count of errored words while Link_Up.

Behaviour:
- Timing:
  - Single clock BitCLK_10; Reset is synchronous and active-high.
  - All outputs are registered.
  - Rx_* appear 1 cycle after the matching decoder inputs.
  - Tx outputs update 1 cycle after the accept cycle.
- Definitions:
  - comma = RxDataK=1 and RxParallel_8=8'hBC.
  - err = Decode_Error | Disparity_Error.
  - clean = !err.
- Reset values:
  - state=HUNT; TxParallel_8=8'hBC, TxDataK=1.
  - Tx_Ready, Bitslip, Link_Up and Rx_Valid = 0; Rx_Data=0, Rx_K=0; Error_Count=0.
  - All internal counters = 0.
- FSM states: HUNT, CHECK, UP.
- TX in HUNT/CHECK:
  - Transmit K28.5 every cycle; Tx_Ready=0.
- TX in UP:
  - Tx_Ready=1.
  - Tx_Valid=1: register the user byte/K and transmit it.
  - Tx_Valid=0: transmit K28.5 idle.
- HUNT:
  - slip_cnt increments each cycle.
  - clean comma: go to CHECK, good_cnt=1, slip_cnt=0.
  - Otherwise, when slip_cnt=SLIP_WAIT-1: Bitslip=1 for exactly one cycle, slip_cnt=0.
  - Bitslip is never asserted in two adjacent cycles.
- CHECK:
  - clean comma: good_cnt+1. On reaching SYNC_COMMAS, go to UP; Link_Up=1 from the next cycle.
  - clean non-comma: counters unchanged.
  - err: go to HUNT with slip_cnt=0 and no Bitslip.
- UP:
  - clean non-comma word: Rx_Valid=1 with that data. Commas and errored words are never forwarded.
  - err: Error_Count+1 (saturating at all-ones), leak+1, run_cnt=0.
  - clean word: run_cnt+1. At GOOD_WINDOW, run_cnt=0 and leak decrements (floor 0).
  - leak reaching ERR_THRESH: go to HUNT; Link_Up, Tx_Ready and Rx_Valid drop the next cycle; leak=0.
  - A user word accepted in that same cycle is still transmitted.
- Error_Count holds its value across link-down; only Reset clears it.
- Reset asserted mid-operation: return to reset values on the next edge regardless of state or any pending Bitslip.

Decomposition:
- Shared package serdes_pkg:
  - K28_5 = 8'hBC.
  - typedef enum link_state_t {HUNT, CHECK, UP}.
- Controller FSM and TX mux stay in this module.
- One sub-module: link_err_monitor.
  - Holds the leaky error counter, run_cnt and the saturating Error_Count.
  - Outputs a force_down flag.

Test Plan:
1. Reset, then 8 clean commas on RX -> Link_Up=1 exactly 1 cycle after the 4th comma. TX is 8'hBC/K=1 throughout training. Bitslip never pulses.
2. Feed a non-comma clean byte 8'h3C for 40 cycles, then commas -> Bitslip pulses at cycle 16 and cycle 32 after reset, each 1 cycle wide. Link_Up is reached 4 commas later.
3. Link up, Tx_Valid=1 with data 8'hA5, K=0 -> Tx_Ready=1 and TxParallel_8=8'hA5 next cycle. Tx_Valid=0 -> 8'hBC/K=1.
4. Link up, RX data 8'h11 clean -> Rx_Valid=1, Rx_Data=8'h11 one cycle later. RX comma -> Rx_Valid=0.
5. Link up, 4 isolated Decode_Error words, each separated by 3 clean words -> Error_Count=4, Link_Up drops, state=HUNT. Same 4 errors each separated by 9 clean words -> link stays up, Error_Count=4.
6. In CHECK with good_cnt=3, assert Disparity_Error -> back to HUNT, no Bitslip. Assert Reset mid-UP -> all outputs at reset values the next cycle, Error_Count=0.

Source files
------------

// File: rtl/serdes_pkg.sv
// -----------------------------------------------------------------------------
// serdes_pkg
// Shared definitions for the 8-bit side of the 8b/10b SerDes path.
//   K28_5        : comma character used for training and idle fill
//   link_state_t : link bring-up controller states
//   isComma()    : true when a decoded byte is the K28.5 comma
// -----------------------------------------------------------------------------
package serdes_pkg;

    localparam logic [7:0] K28_5 = 8'hBC;

    typedef enum logic [1:0] {
        HUNT,
        CHECK,
        UP
    } link_state_t;

    function automatic logic isComma(input logic [7:0] data, input logic isK);
        return isK && (data == K28_5);
    endfunction

endpackage

// File: rtl/link_sync_ctrl_if.sv
// -----------------------------------------------------------------------------
// link_sync_ctrl_if
// Bundles the user-side and decoder/encoder-side signals of link_sync_ctrl.
//   Tx_Valid, Tx_Data_User, Tx_K_User      : user word to transmit
//   RxParallel_8, RxDataK                   : decoded byte from the decoder
//   Decode_Error, Disparity_Error           : decoder error flags for this word
//   TxParallel_8, TxDataK                   : byte and K flag to the encoder
//   Tx_Ready                                : user word accepted when Tx_Valid=1
//   Bitslip                                 : alignment shift request to the SIPO
//   Link_Up                                 : link trained
//   Rx_Valid, Rx_Data, Rx_K                 : received user word
//   Error_Count                             : saturating errored-word count
// modport slave  : the controller side (drives the outputs above)
// modport master : the user/PHY side (drives the inputs above)
// -----------------------------------------------------------------------------
interface link_sync_ctrl_if #(
    parameter int ERR_CNT_W = 16
);

    logic                 Tx_Valid;
    logic [7:0]           Tx_Data_User;
    logic                 Tx_K_User;
    logic [7:0]           RxParallel_8;
    logic                 RxDataK;
    logic                 Decode_Error;
    logic                 Disparity_Error;

    logic [7:0]           TxParallel_8;
    logic                 TxDataK;
    logic                 Tx_Ready;
    logic                 Bitslip;
    logic                 Link_Up;
    logic                 Rx_Valid;
    logic [7:0]           Rx_Data;
    logic                 Rx_K;
    logic [ERR_CNT_W-1:0] Error_Count;

    modport slave (
        input  Tx_Valid, Tx_Data_User, Tx_K_User,
        input  RxParallel_8, RxDataK, Decode_Error, Disparity_Error,
        output TxParallel_8, TxDataK, Tx_Ready, Bitslip, Link_Up,
        output Rx_Valid, Rx_Data, Rx_K, Error_Count
    );

    modport master (
        output Tx_Valid, Tx_Data_User, Tx_K_User,
        output RxParallel_8, RxDataK, Decode_Error, Disparity_Error,
        input  TxParallel_8, TxDataK, Tx_Ready, Bitslip, Link_Up,
        input  Rx_Valid, Rx_Data, Rx_K, Error_Count
    );

endinterface

// File: rtl/link_err_monitor.sv
// -----------------------------------------------------------------------------
// link_err_monitor
// Tracks decoded word quality while the link is up.
//   i_clk          : word clock
//   i_reset        : synchronous active-high reset
//   i_active       : link is up; counting only happens while high
//   i_err          : current word is errored (decode or disparity)
//   o_forceDown    : this word pushes the leaky counter to the threshold
//   o_errorCount   : saturating count of errored words seen while active
// The leaky counter rises by one per errored word and falls by one after every
// GOOD_WINDOW consecutive clean words, so sparse errors are forgiven while a
// burst drives the link down.
// -----------------------------------------------------------------------------
module link_err_monitor #(
    parameter int ERR_THRESH  = 4,
    parameter int GOOD_WINDOW = 8,
    parameter int ERR_CNT_W   = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_active,
    input  logic                 i_err,
    output logic                 o_forceDown,
    output logic [ERR_CNT_W-1:0] o_errorCount
);

    localparam int LEAK_W = $clog2(ERR_THRESH + 1);
    localparam int RUN_W  = $clog2(GOOD_WINDOW + 1);

    logic [LEAK_W-1:0]    r_leak;
    logic [RUN_W-1:0]     r_runCnt;
    logic [ERR_CNT_W-1:0] r_errorCount;
    logic [LEAK_W-1:0]    w_leakInc;
    logic                 w_forceDown;

    // The leak never rests at the threshold, so leak+1 always fits LEAK_W.
    // Force-down is decided combinationally so the controller leaves UP on
    // the same edge that samples the offending word.
    assign w_leakInc   = r_leak + LEAK_W'(1);
    assign w_forceDown = i_active && i_err && (w_leakInc >= LEAK_W'(ERR_THRESH));

    assign o_forceDown  = w_forceDown;
    assign o_errorCount = r_errorCount;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_leak       <= '0;
            r_runCnt     <= '0;
            r_errorCount <= '0;
        end else if (!i_active) begin
            // Each link-up session starts with a clean slate; the total
            // error count is kept.
            r_leak   <= '0;
            r_runCnt <= '0;
        end else if (i_err) begin
            if (r_errorCount != {ERR_CNT_W{1'b1}}) begin
                r_errorCount <= r_errorCount + ERR_CNT_W'(1);
            end
            r_leak   <= w_forceDown ? '0 : w_leakInc;
            r_runCnt <= '0;
        end else if (r_runCnt == RUN_W'(GOOD_WINDOW - 1)) begin
            r_runCnt <= '0;
            if (r_leak != '0) begin
                r_leak <= r_leak - LEAK_W'(1);
            end
        end else begin
            r_runCnt <= r_runCnt + RUN_W'(1);
        end
    end

endmodule

// File: rtl/link_sync_ctrl.sv
// -----------------------------------------------------------------------------
// link_sync_ctrl
// Link bring-up and word-alignment controller for the 8b/10b path.
//   i_BitCLK_10 : word clock, one cycle per 10-bit symbol
//   i_Reset     : synchronous active-high reset
//   io_link     : link_sync_ctrl_if slave port (user TX/RX, decoder flags,
//                 encoder byte, Bitslip, Link_Up, Error_Count)
// Trains with K28.5 commas, pulses Bitslip while hunting for alignment,
// declares the link up after SYNC_COMMAS consecutive clean commas, then
// passes user data until the error monitor forces the link back down.
// All outputs are registered.
// -----------------------------------------------------------------------------
module link_sync_ctrl
    import serdes_pkg::*;
#(
    parameter int SLIP_WAIT   = 16,
    parameter int SYNC_COMMAS = 4,
    parameter int ERR_THRESH  = 4,
    parameter int GOOD_WINDOW = 8,
    parameter int ERR_CNT_W   = 16
) (
    input  logic            i_BitCLK_10,
    input  logic            i_Reset,
    link_sync_ctrl_if.slave io_link
);

    localparam int SLIP_W = $clog2(SLIP_WAIT + 1);
    localparam int GOOD_W = $clog2(SYNC_COMMAS + 1);

    link_state_t          r_state;
    logic [SLIP_W-1:0]    r_slipCnt;
    logic [GOOD_W-1:0]    r_goodCnt;
    logic [7:0]           r_txData;
    logic                 r_txK;
    logic                 r_txReady;
    logic                 r_bitslip;
    logic                 r_linkUp;
    logic                 r_rxValid;
    logic [7:0]           r_rxData;
    logic                 r_rxK;

    logic                 w_comma;
    logic                 w_err;
    logic                 w_cleanComma;
    logic                 w_forceDown;
    logic [ERR_CNT_W-1:0] w_errorCount;

    assign w_comma      = isComma(io_link.RxParallel_8, io_link.RxDataK);
    assign w_err        = io_link.Decode_Error | io_link.Disparity_Error;
    assign w_cleanComma = w_comma && !w_err;

    link_err_monitor #(
        .ERR_THRESH  (ERR_THRESH),
        .GOOD_WINDOW (GOOD_WINDOW),
        .ERR_CNT_W   (ERR_CNT_W)
    ) u_errMonitor (
        .i_clk        (i_BitCLK_10),
        .i_reset      (i_Reset),
        .i_active     (r_state == UP),
        .i_err        (w_err),
        .o_forceDown  (w_forceDown),
        .o_errorCount (w_errorCount)
    );

    assign io_link.TxParallel_8 = r_txData;
    assign io_link.TxDataK      = r_txK;
    assign io_link.Tx_Ready     = r_txReady;
    assign io_link.Bitslip      = r_bitslip;
    assign io_link.Link_Up      = r_linkUp;
    assign io_link.Rx_Valid     = r_rxValid;
    assign io_link.Rx_Data      = r_rxData;
    assign io_link.Rx_K         = r_rxK;
    assign io_link.Error_Count  = w_errorCount;

    // Controller FSM with the TX mux. Tx_Ready and Link_Up are registered
    // copies of "next state is UP", so a user word is accepted whenever the
    // registered Tx_Ready is high; that still holds on the edge that drops
    // the link, which lets the last accepted word go out.
    always_ff @(posedge i_BitCLK_10) begin
        if (i_Reset) begin
            r_state   <= HUNT;
            r_slipCnt <= '0;
            r_goodCnt <= '0;
            r_txData  <= K28_5;
            r_txK     <= 1'b1;
            r_txReady <= 1'b0;
            r_bitslip <= 1'b0;
            r_linkUp  <= 1'b0;
            r_rxValid <= 1'b0;
            r_rxData  <= '0;
            r_rxK     <= 1'b0;
        end else begin
            if (r_txReady && io_link.Tx_Valid) begin
                r_txData <= io_link.Tx_Data_User;
                r_txK    <= io_link.Tx_K_User;
            end else begin
                r_txData <= K28_5;
                r_txK    <= 1'b1;
            end

            r_bitslip <= 1'b0;
            r_rxValid <= 1'b0;

            case (r_state)
                HUNT: begin
                    if (w_cleanComma) begin
                        r_slipCnt <= '0;
                        if (SYNC_COMMAS <= 1) begin
                            r_state   <= UP;
                            r_goodCnt <= '0;
                            r_linkUp  <= 1'b1;
                            r_txReady <= 1'b1;
                        end else begin
                            r_state   <= CHECK;
                            r_goodCnt <= GOOD_W'(1);
                        end
                    end else if (r_slipCnt == SLIP_W'(SLIP_WAIT - 1)) begin
                        // Counter restarts from zero after a pulse, so two
                        // pulses can never land in adjacent cycles.
                        r_bitslip <= 1'b1;
                        r_slipCnt <= '0;
                    end else begin
                        r_slipCnt <= r_slipCnt + SLIP_W'(1);
                    end
                end

                CHECK: begin
                    if (w_err) begin
                        r_state   <= HUNT;
                        r_slipCnt <= '0;
                        r_goodCnt <= '0;
                    end else if (w_comma) begin
                        if (r_goodCnt == GOOD_W'(SYNC_COMMAS - 1)) begin
                            r_state   <= UP;
                            r_goodCnt <= '0;
                            r_linkUp  <= 1'b1;
                            r_txReady <= 1'b1;
                        end else begin
                            r_goodCnt <= r_goodCnt + GOOD_W'(1);
                        end
                    end
                end

                UP: begin
                    if (!w_err && !w_comma) begin
                        r_rxValid <= 1'b1;
                        r_rxData  <= io_link.RxParallel_8;
                        r_rxK     <= io_link.RxDataK;
                    end
                    if (w_forceDown) begin
                        r_state   <= HUNT;
                        r_slipCnt <= '0;
                        r_linkUp  <= 1'b0;
                        r_txReady <= 1'b0;
                    end
                end

                default: begin
                    r_state <= HUNT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_link_sync_ctrl.sv
// -----------------------------------------------------------------------------
// tb_link_sync_ctrl
// Self-checking bench for link_sync_ctrl. A behavioural model tracks the
// link mode and counters from the behavioural rules and is compared against
// every output on every cycle; directed sequences add literal expectations.
// -----------------------------------------------------------------------------
module tb_link_sync_ctrl;
    import serdes_pkg::*;

    localparam int ECW     = 3;
    localparam int SW      = 16;
    localparam int SC      = 4;
    localparam int ET      = 4;
    localparam int GW      = 8;
    localparam int ERR_MAX = (1 << ECW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    link_sync_ctrl_if #(.ERR_CNT_W(ECW)) bus ();

    link_sync_ctrl #(
        .SLIP_WAIT   (SW),
        .SYNC_COMMAS (SC),
        .ERR_THRESH  (ET),
        .GOOD_WINDOW (GW),
        .ERR_CNT_W   (ECW)
    ) dut (
        .i_BitCLK_10 (clk),
        .i_Reset     (rst),
        .io_link     (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    // Model state: link mode 0=hunting, 1=checking, 2=up
    bit         modelLive = 1'b0;
    int         mMode, mHuntCycles, mCommas, mLeak, mRun, mErrTotal;
    logic       mComma, mBad;
    logic [7:0] eTx, eRxData;
    logic       eTxK, eTxReady, eBitslip, eLink, eRxValid, eRxK;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model, advanced on every clock edge from the sampled inputs.
    always @(posedge clk) begin
        mComma = bus.RxDataK && (bus.RxParallel_8 == 8'hBC);
        mBad   = bus.Decode_Error || bus.Disparity_Error;
        if (rst) begin
            mMode = 0; mHuntCycles = 0; mCommas = 0; mLeak = 0; mRun = 0; mErrTotal = 0;
            eTx = 8'hBC; eTxK = 1'b1; eTxReady = 1'b0; eBitslip = 1'b0; eLink = 1'b0;
            eRxValid = 1'b0; eRxData = 8'h00; eRxK = 1'b0;
            modelLive = 1'b1;
        end else begin
            if (eTxReady && bus.Tx_Valid) begin
                eTx = bus.Tx_Data_User; eTxK = bus.Tx_K_User;
            end else begin
                eTx = 8'hBC; eTxK = 1'b1;
            end
            eBitslip = 1'b0;
            eRxValid = 1'b0;
            if (mMode == 0) begin
                if (mComma && !mBad) begin
                    mCommas = 1; mHuntCycles = 0;
                    mMode = (mCommas >= SC) ? 2 : 1;
                end else begin
                    mHuntCycles++;
                    if (mHuntCycles == SW) begin
                        eBitslip = 1'b1; mHuntCycles = 0;
                    end
                end
            end else if (mMode == 1) begin
                if (mBad) begin
                    mMode = 0; mHuntCycles = 0; mCommas = 0;
                end else if (mComma) begin
                    mCommas++;
                    if (mCommas >= SC) mMode = 2;
                end
            end else begin
                if (mBad) begin
                    mErrTotal = (mErrTotal < ERR_MAX) ? mErrTotal + 1 : ERR_MAX;
                    mLeak++; mRun = 0;
                    if (mLeak >= ET) begin
                        mMode = 0; mHuntCycles = 0;
                    end
                end else begin
                    if (!mComma) begin
                        eRxValid = 1'b1; eRxData = bus.RxParallel_8; eRxK = bus.RxDataK;
                    end
                    mRun++;
                    if (mRun == GW) begin
                        mRun = 0;
                        if (mLeak > 0) mLeak--;
                    end
                end
            end
            if (mMode != 2) begin
                mLeak = 0; mRun = 0;
            end
            eLink    = (mMode == 2);
            eTxReady = (mMode == 2);
        end
    end

    // Per-cycle comparison against the model, away from the clock edge.
    always @(posedge clk) begin
        #1;
        if (modelLive) begin
            checkOutput("model TxParallel_8", 32'(bus.TxParallel_8), 32'(eTx));
            checkOutput("model TxDataK", 32'(bus.TxDataK), 32'(eTxK));
            checkOutput("model Tx_Ready", 32'(bus.Tx_Ready), 32'(eTxReady));
            checkOutput("model Bitslip", 32'(bus.Bitslip), 32'(eBitslip));
            checkOutput("model Link_Up", 32'(bus.Link_Up), 32'(eLink));
            checkOutput("model Rx_Valid", 32'(bus.Rx_Valid), 32'(eRxValid));
            checkOutput("model Error_Count", 32'(bus.Error_Count), 32'(mErrTotal));
            if (eRxValid) begin
                checkOutput("model Rx_Data", 32'(bus.Rx_Data), 32'(eRxData));
                checkOutput("model Rx_K", 32'(bus.Rx_K), 32'(eRxK));
            end
        end
    end

    // One cycle of stimulus; on return the outputs reflect this cycle's inputs.
    task automatic applyStimulus(input logic [7:0] rxd, input logic rxk, input logic dec,
                                 input logic disp, input logic tv, input logic [7:0] td,
                                 input logic tk);
        bus.RxParallel_8    = rxd;
        bus.RxDataK         = rxk;
        bus.Decode_Error    = dec;
        bus.Disparity_Error = disp;
        bus.Tx_Valid        = tv;
        bus.Tx_Data_User    = td;
        bus.Tx_K_User       = tk;
        @(posedge clk);
        #1;
    endtask

    task automatic sendComma();
        applyStimulus(8'hBC, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic sendData(input logic [7:0] d);
        applyStimulus(d, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic sendErr();
        applyStimulus(8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic doReset();
        rst = 1'b1;
        sendData(8'h00);
        rst = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " TxParallel_8"}, 32'(bus.TxParallel_8), 32'h0BC);
        checkOutput({tag, " TxDataK"}, 32'(bus.TxDataK), 32'd1);
        checkOutput({tag, " Tx_Ready"}, 32'(bus.Tx_Ready), 32'd0);
        checkOutput({tag, " Bitslip"}, 32'(bus.Bitslip), 32'd0);
        checkOutput({tag, " Link_Up"}, 32'(bus.Link_Up), 32'd0);
        checkOutput({tag, " Rx_Valid"}, 32'(bus.Rx_Valid), 32'd0);
        checkOutput({tag, " Rx_Data"}, 32'(bus.Rx_Data), 32'd0);
        checkOutput({tag, " Rx_K"}, 32'(bus.Rx_K), 32'd0);
        checkOutput({tag, " Error_Count"}, 32'(bus.Error_Count), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.RxParallel_8 = 8'h00; bus.RxDataK = 1'b0; bus.Decode_Error = 1'b0;
        bus.Disparity_Error = 1'b0; bus.Tx_Valid = 1'b0; bus.Tx_Data_User = 8'h00;
        bus.Tx_K_User = 1'b0;

        // Clean commas bring the link up one cycle after the fourth
        doReset();
        checkResetValues("reset");
        for (int k = 0; k < 8; k++) begin
            sendComma();
            checkOutput("train Link_Up", 32'(bus.Link_Up), 32'(k >= 3));
            checkOutput("train TxParallel_8", 32'(bus.TxParallel_8), 32'h0BC);
            checkOutput("train TxDataK", 32'(bus.TxDataK), 32'd1);
            checkOutput("train Bitslip", 32'(bus.Bitslip), 32'd0);
        end

        // Misaligned data: Bitslip visible in cycles 16 and 32 after reset
        doReset();
        for (int k = 0; k < 40; k++) begin
            sendData(8'h3C);
            checkOutput("hunt Bitslip", 32'(bus.Bitslip), 32'((k == 15) || (k == 31)));
        end
        for (int k = 40; k < 44; k++) begin
            sendComma();
            checkOutput("hunt Link_Up", 32'(bus.Link_Up), 32'(k == 43));
        end

        // User TX accepted, then idle commas
        checkOutput("tx Tx_Ready before", 32'(bus.Tx_Ready), 32'd1);
        applyStimulus(8'hBC, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0);
        checkOutput("tx TxParallel_8 user", 32'(bus.TxParallel_8), 32'h0A5);
        checkOutput("tx TxDataK user", 32'(bus.TxDataK), 32'd0);
        checkOutput("tx Tx_Ready", 32'(bus.Tx_Ready), 32'd1);
        sendComma();
        checkOutput("tx TxParallel_8 idle", 32'(bus.TxParallel_8), 32'h0BC);
        checkOutput("tx TxDataK idle", 32'(bus.TxDataK), 32'd1);

        // RX forwarding: data and non-comma K chars pass, commas do not
        sendData(8'h11);
        checkOutput("rx Rx_Valid data", 32'(bus.Rx_Valid), 32'd1);
        checkOutput("rx Rx_Data", 32'(bus.Rx_Data), 32'h011);
        checkOutput("rx Rx_K data", 32'(bus.Rx_K), 32'd0);
        applyStimulus(8'h1C, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("rx Rx_Valid K", 32'(bus.Rx_Valid), 32'd1);
        checkOutput("rx Rx_K", 32'(bus.Rx_K), 32'd1);
        sendComma();
        checkOutput("rx Rx_Valid comma", 32'(bus.Rx_Valid), 32'd0);

        // Dense errors (3 clean words apart) force the link down
        for (int e = 0; e < 4; e++) begin
            sendErr();
            checkOutput("dense Link_Up", 32'(bus.Link_Up), 32'(e < 3));
            checkOutput("dense Error_Count", 32'(bus.Error_Count), 32'(e + 1));
            if (e < 3) for (int c = 0; c < 3; c++) sendData(8'h22);
        end
        sendData(8'h33);
        checkOutput("down Tx_Ready", 32'(bus.Tx_Ready), 32'd0);
        checkOutput("down Rx_Valid", 32'(bus.Rx_Valid), 32'd0);
        checkOutput("down Error_Count held", 32'(bus.Error_Count), 32'd4);

        // Second session: Error_Count keeps climbing and saturates
        for (int k = 0; k < 4; k++) sendComma();
        checkOutput("relink Link_Up", 32'(bus.Link_Up), 32'd1);
        for (int e = 0; e < 4; e++) begin
            sendErr();
            if (e < 3) for (int c = 0; c < 3; c++) sendData(8'h22);
        end
        checkOutput("saturate Error_Count", 32'(bus.Error_Count), 32'd7);
        checkOutput("saturate Link_Up", 32'(bus.Link_Up), 32'd0);

        // Sparse errors (9 clean words apart) are forgiven
        doReset();
        for (int k = 0; k < 4; k++) sendComma();
        for (int e = 0; e < 4; e++) begin
            sendErr();
            if (e < 3) for (int c = 0; c < 9; c++) sendData(8'h44);
        end
        checkOutput("sparse Link_Up", 32'(bus.Link_Up), 32'd1);
        checkOutput("sparse Error_Count", 32'(bus.Error_Count), 32'd4);

        // Error during CHECK with three commas counted returns to HUNT
        doReset();
        for (int k = 0; k < 3; k++) sendComma();
        applyStimulus(8'hBC, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput("check-err Bitslip", 32'(bus.Bitslip), 32'd0);
        checkOutput("check-err Link_Up", 32'(bus.Link_Up), 32'd0);
        for (int k = 0; k < 4; k++) begin
            sendComma();
            checkOutput("check-err relink", 32'(bus.Link_Up), 32'(k == 3));
        end

        // Reset in UP with nonzero error count and pending user word
        sendData(8'h77);
        sendErr();
        checkOutput("pre-reset Error_Count", 32'(bus.Error_Count), 32'd1);
        rst = 1'b1;
        applyStimulus(8'h66, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0);
        rst = 1'b0;
        checkResetValues("midUP reset");

        // Reset on the cycle a Bitslip would otherwise fire
        for (int k = 0; k < 15; k++) sendData(8'h3C);
        rst = 1'b1;
        sendData(8'h3C);
        rst = 1'b0;
        checkResetValues("slip reset");
        sendData(8'h3C);
        checkOutput("slip reset after", 32'(bus.Bitslip), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
